// File: rtl/button_event_queue.sv
// Button event queue: captures one-cycle CMD/KEY pulses into pending bits,
// arbitrates them by fixed priority and queues them for a valid/ready consumer.
module button_event_queue #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [3:0]       CMD_En,
  input  logic [3:0]       KEY_En,
  input  logic             ENABLE,
  input  logic             EVT_Ready,
  input  logic             CLR_OVF,
  output logic             EVT_Valid,
  output logic [2:0]       EVT_Code,
  output logic [PTR_W:0]   EVT_Count,
  output logic             OVF
);

  logic [7:0]       pend;
  logic [7:0]       pulse;
  logic [7:0]       sel;
  logic [7:0]       clr;
  logic [2:0]       code;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             loss;

  assign pulse     = ENABLE ? {CMD_En, KEY_En} : 8'h00;
  assign full      = EVT_Count == (PTR_W+1)'(FIFO_DEPTH);
  assign push      = (|pend) && !full;
  assign pop       = EVT_Valid && EVT_Ready;
  assign clr       = push ? sel : 8'h00;
  assign loss      = |(pulse & pend & ~clr);
  assign EVT_Valid = EVT_Count != '0;
  assign EVT_Code  = mem[rd_ptr];

  // Scan low priority first so the highest-priority set bit wins last
  always_comb begin
    sel  = '0;
    code = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        code   = {1'b0, 2'(i)};
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (pend[4+i]) begin
        sel      = '0;
        sel[4+i] = 1'b1;
        code     = {1'b1, 2'(i)};
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pend      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      EVT_Count <= '0;
      OVF       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pend <= (pend & ~clr) | pulse;
      OVF  <= loss | (OVF & ~CLR_OVF);
      if (push) begin
        mem[wr_ptr] <= code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      EVT_Count <= EVT_Count + 1'b1;
      else if (pop && !push) EVT_Count <= EVT_Count - 1'b1;
    end
  end

endmodule
